// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_ERROR   = 2'd2
  } hz_state_e;

  localparam int REG_AW_DEF = 5;
  localparam int X0_IDX     = 0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-wait freeze
// with timeout, and saturating stall/flush counters.
//
// state   | meaning
// RUN     | normal flow, no outstanding memory wait
// MEMWAIT | data memory not ready, pipeline frozen, timeout running
// ERROR   | memory timed out; permanent freeze until reset
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_write,
  output logic              ex_mem_write,
  output logic              ctrl_select,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mem_wb_bubble,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT);

  hz_state_e         state_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              mem_err_q;

  logic freeze, branch, load_use, stall_inc, flush_inc;

  assign freeze   = (state_q == ST_ERROR) || (mem_req && !mem_ready);
  assign branch   = mem_branch_taken;
  assign load_use = ex_memread && (ex_rd != REG_AW'(X0_IDX)) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // Lower-priority events are masked so each cycle counts once.
  assign stall_inc = freeze || (!branch && load_use);
  assign flush_inc = !freeze && branch;

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    ctrl_select   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!rstn) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      ctrl_select  = 1'b0;
    end else if (freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (branch) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      ctrl_select  = 1'b0;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ctrl_select = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            state_q    <= ST_MEMWAIT;
            wait_cnt_q <= WAIT_W'(1);
          end
        end
        ST_MEMWAIT: begin
          // A dropped request is treated the same as a completed access.
          if (!mem_req || mem_ready) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state_q   <= ST_ERROR;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end
        ST_ERROR: begin
          state_q <= ST_ERROR;
        end
        default: begin
          state_q    <= ST_RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  assign mem_err = mem_err_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (stall_inc),
    .cnt  (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (flush_inc),
    .cnt  (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus multi-cycle sequences.
module tb_hazard_ctrl;

  localparam int REG_AW      = 5;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  // {pc_write, if_id_write, id_ex_write, ex_mem_write, ctrl_select,
  //  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble}
  localparam logic [8:0] O_RST = 9'b0000_0_000_0;
  localparam logic [8:0] O_DEF = 9'b1111_1_000_0;
  localparam logic [8:0] O_LU  = 9'b0011_0_000_0;
  localparam logic [8:0] O_BR  = 9'b1111_0_111_0;
  localparam logic [8:0] O_FRZ = 9'b0000_1_000_1;

  logic clk = 1'b0;
  logic rstn;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_memread, mem_branch_taken, mem_req, mem_ready;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write, ctrl_select;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [8:0] outs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(REG_AW), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_branch_taken(mem_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .ctrl_select(ctrl_select),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .mem_wb_bubble(mem_wb_bubble), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign outs = {pc_write, if_id_write, id_ex_write, ex_mem_write, ctrl_select,
                 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble};

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       memread;
    logic [4:0] rd;
    logic       br;
    logic       req;
    logic       rdy;
    logic [8:0] exp_o;
    int         exp_stall;
    int         exp_flush;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic use1,
                       input logic use2, input logic memread, input logic [4:0] rd,
                       input logic br, input logic req, input logic rdy);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = use1; id_use_rs2 = use2;
    ex_memread = memread; ex_rd = rd; mem_branch_taken = br;
    mem_req = req; mem_ready = rdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Inputs change just after a falling edge; comb outputs sampled 2ns later.
  task automatic settle();
    #2;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    settle();
    check("rst_outs", int'(outs), int'(O_RST));
    check("rst_mem_err", int'(mem_err), 0);
    check("rst_stall_cnt", int'(stall_cnt), 0);
    check("rst_flush_cnt", int'(flush_cnt), 0);
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b1;
    idle();
    //          rs1    rs2   u1    u2   mrd   rd     br    req   rdy    exp   stall flush
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_DEF, 0, 0};
    vecs[1]  = '{5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_LU,  1, 0};
    vecs[2]  = '{5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, O_DEF, 1, 0};
    vecs[3]  = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, O_DEF, 1, 0};
    vecs[4]  = '{5'd9, 5'd1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, O_DEF, 1, 0};
    vecs[5]  = '{5'd7, 5'd2, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_LU,  2, 0};
    vecs[6]  = '{5'd7, 5'd2, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, O_DEF, 2, 0};
    vecs[7]  = '{5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, O_BR,  2, 1};
    vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, O_BR,  2, 2};
    vecs[9]  = '{5'd6, 5'd31,1'b0, 1'b1, 1'b1, 5'd31,1'b0, 1'b1, 1'b1, O_LU,  3, 2};
    vecs[10] = '{5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, O_BR,  3, 3};

    tick();
    do_reset();

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].use1, vecs[i].use2, vecs[i].memread,
            vecs[i].rd, vecs[i].br, vecs[i].req, vecs[i].rdy);
      settle();
      check($sformatf("vec%0d_outs", i), int'(outs), int'(vecs[i].exp_o));
      tick();
      check($sformatf("vec%0d_stall", i), int'(stall_cnt), vecs[i].exp_stall);
      check($sformatf("vec%0d_flush", i), int'(flush_cnt), vecs[i].exp_flush);
    end

    // Branch beats load-use from a clean reset.
    do_reset();
    drive(5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    settle();
    check("br_lu_outs", int'(outs), int'(O_BR));
    tick();
    check("br_lu_flush", int'(flush_cnt), 1);
    check("br_lu_stall", int'(stall_cnt), 0);

    // Three not-ready cycles freeze, fourth completes; branch ignored while frozen.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, (i == 1), 1'b1, 1'b0);
      settle();
      check($sformatf("wait%0d_outs", i), int'(outs), int'(O_FRZ));
      tick();
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    settle();
    check("wait_done_outs", int'(outs), int'(O_DEF));
    tick();
    check("wait_stall", int'(stall_cnt), 3);
    check("wait_flush", int'(flush_cnt), 0);
    check("wait_mem_err", int'(mem_err), 0);
    idle();
    settle();
    check("wait_back_run", int'(outs), int'(O_DEF));
    tick();

    // Timeout: error only after the fourth consecutive not-ready cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      settle();
      check($sformatf("to%0d_outs", i), int'(outs), int'(O_FRZ));
      check($sformatf("to%0d_err_before", i), int'(mem_err), 0);
      tick();
    end
    check("to_mem_err", int'(mem_err), 1);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    settle();
    check("err_ready_outs", int'(outs), int'(O_FRZ));
    tick();
    idle();
    settle();
    check("err_idle_outs", int'(outs), int'(O_FRZ));
    tick();
    check("err_stall", int'(stall_cnt), 6);
    check("err_sticky", int'(mem_err), 1);
    do_reset();
    settle();
    check("post_err_outs", int'(outs), int'(O_DEF));
    check("post_err_mem_err", int'(mem_err), 0);
    tick();

    // Reset mid-wait restarts the timeout from zero.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    check("midrst_no_err", int'(mem_err), 0);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    settle();
    check("midrst_done_outs", int'(outs), int'(O_DEF));
    tick();

    // 20 load-use stalls saturate a 4-bit counter at 15.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("sat_stall", int'(stall_cnt), 15);
    idle();
    tick();
    check("sat_hold", int'(stall_cnt), 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core; the producer side of the ID/EX bubble mux select (ctrl_select: 1 = pass decoded controls, 0 = zero them).
- Detects load-use hazards, taken-branch redirects and data-memory wait states.
- Drives PC/stage-register write enables, flushes and the bubble select.
- Holds a timeout FSM for memory waits and saturating stall/flush performance counters.

Parameters:
REG_AW, 5, register-index width
MEM_TIMEOUT, 64, max consecutive not-ready cycles before error (>=2)
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
id_rs1  in  REG_AW  IF/ID source reg 1
id_rs2  in  REG_AW  IF/ID source reg 2
id_use_rs1  in  1  instruction in ID reads rs1
id_use_rs2  in  1  instruction in ID reads rs2
ex_memread  in  1  ID/EX instruction is a load
ex_rd  in  REG_AW  ID/EX destination reg
mem_branch_taken  in  1  EX/MEM branch/jump resolved taken
mem_req  in  1  EX/MEM stage holds a load/store
mem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID register enable
id_ex_write  out  1  ID/EX register enable
ex_mem_write  out  1  EX/MEM register enable
ctrl_select  out  1  1 = pass controls into ID/EX, 0 = bubble
if_id_flush  out  1  clear IF/ID
id_ex_flush  out  1  clear ID/EX
ex_mem_flush  out  1  clear EX/MEM
mem_wb_bubble  out  1  insert bubble into MEM/WB
mem_err  out  1  sticky memory-timeout error
stall_cnt  out  CNT_W  cycles with any stall or freeze
flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=RUN, wait_cnt=0, mem_err=0, counters=0.
  - While reset is held, all write enables=0, ctrl_select=0, flushes=0, mem_wb_bubble=0.
- Outputs are combinational from state and inputs, same cycle. Counters, state and mem_err are registered.
- Default (no event): all write enables=1, ctrl_select=1, flushes=0, mem_wb_bubble=0.
- Events, in priority order:
  1. Freeze (state=ERROR, or mem_req && !mem_ready):
     - pc_write, if_id_write, id_ex_write, ex_mem_write=0; ctrl_select=1; mem_wb_bubble=1; no flushes.
     - Branch and load-use are ignored this cycle and re-evaluated on unfreeze.
  2. Branch (mem_branch_taken):
     - if_id_flush=id_ex_flush=ex_mem_flush=1; ctrl_select=0; pc_write=1 (redirect).
  3. Load-use: ex_memread && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)):
     - pc_write=0, if_id_write=0, ctrl_select=0; others default.
     - Self-clears next cycle because the bubble clears ex_memread.
- FSM:
  - RUN: mem_req && !mem_ready -> MEMWAIT with wait_cnt=1. Otherwise stay.
  - MEMWAIT:
    - mem_ready=1 -> RUN, wait_cnt=0; no freeze that cycle.
    - !mem_ready && wait_cnt==MEM_TIMEOUT-1 -> ERROR, mem_err=1.
    - Otherwise wait_cnt+1.
    - mem_req dropping while in MEMWAIT counts as ready.
  - ERROR: permanent freeze; exit only by reset.
- Counters:
  - stall_cnt +1 per cycle with freeze or load-use.
  - flush_cnt +1 per cycle with branch flush.
  - Both saturate at all-ones; no wrap.
- Reset asserted mid-wait returns to RUN immediately. Outputs follow the reset rule.

Decomposition:
- Shared package hazard_pkg:
  - state encoding RUN=2'd0, MEMWAIT=2'd1, ERROR=2'd2.
  - REG_AW default.
  - x0 index constant.
- One sub-module, sat_counter (CNT_W, inc): instantiated twice for stall_cnt/flush_cnt.

Test Plan:
1. Load x5 in EX, ID uses rs2=x5 -> one cycle pc_write=0, if_id_write=0, ctrl_select=0; next cycle all default; stall_cnt=1.
2. Load with ex_rd=0, id_rs1=0, id_use_rs1=1 -> no stall, ctrl_select=1, stall_cnt unchanged.
3. mem_branch_taken=1 together with a load-use condition -> three flushes=1, pc_write=1, ctrl_select=0; flush_cnt=1, stall_cnt=0.
4. mem_req=1, mem_ready low 3 cycles then high -> freeze 3 cycles (all enables 0, mem_wb_bubble=1), back to RUN on cycle 4; stall_cnt=3.
5. MEM_TIMEOUT=4, mem_ready held low -> mem_err=1 after 4th not-ready cycle, freeze persists after mem_ready=1; rstn pulse clears state, mem_err and counters.
6. CNT_W=4, 20 load-use stalls -> stall_cnt saturates at 15.
